// File: rtl/pipe_run_monitor.sv
// pipe_run_monitor: gates the pipelined CPU, counts executed cycles, halts on
// breakpoint / timeout / invalid PC, then streams the halt PC and the register
// file out over a valid/ready port.
module pipe_run_monitor #(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int NUM_BP   = 4,
    parameter  int CNT_W    = 16,
    parameter  int NUM_REGS = 32,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [CNT_W-1:0]         timeout,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     pc_valid,
    output logic                     cpu_run,
    output logic [SEL_W-1:0]         reg_sel,
    input  logic [DATA_W-1:0]        reg_data,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic [DATA_W-1:0]        dump_data,
    output logic [SEL_W:0]           dump_idx,
    output logic                     dump_last,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [NUM_BP-1:0]        bp_hit,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     done
);

    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   halt_pc;
    logic [NUM_BP-1:0]   bp_vec, bp_first;
    logic                inv, bp_any, to, hit;
    logic [1:0]          cause_nxt;
    logic                last_beat, xfer;

    // Zero-extend or truncate the halt PC into a data-width beat.
    function automatic logic [DATA_W-1:0] pc_to_data(input logic [ADDR_W-1:0] p);
        logic [MAX_W-1:0] w;
        w = MAX_W'(p);
        return w[DATA_W-1:0];
    endfunction

    // Halt conditions on the current PC and cycle count, with cause priority.
    always_comb begin
        bp_vec   = '0;
        bp_first = '0;
        for (int i = 0; i < NUM_BP; i++)
            bp_vec[i] = bp_en[i] & (pc == bp_addr[i*ADDR_W +: ADDR_W]);
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_vec[i]) begin
                bp_first    = '0;
                bp_first[i] = 1'b1;
            end
        end
        inv    = !pc_valid;
        bp_any = |bp_vec;
        to     = (timeout != '0) && (cycle_count == timeout);
        hit    = inv | bp_any | to;
        if (inv)         cause_nxt = 2'b11;
        else if (bp_any) cause_nxt = 2'b01;
        else if (to)     cause_nxt = 2'b10;
        else             cause_nxt = 2'b00;
    end

    assign last_beat = (dump_idx == (SEL_W+1)'(NUM_REGS));
    assign xfer      = dump_valid & dump_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start)            state_nxt = RUN;
            RUN:        if (hit)              state_nxt = DUMP;
            DUMP:       if (xfer && last_beat) state_nxt = DONE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state: run gate and the dump beat payload.
    always_comb begin
        cpu_run    = (state == RUN) && !hit;
        dump_valid = (state == DUMP);
        dump_last  = dump_valid && last_beat;
        reg_sel    = '0;
        dump_data  = '0;
        if (state == DUMP) begin
            if (dump_idx == '0) begin
                dump_data = pc_to_data(halt_pc);
            end else begin
                reg_sel   = SEL_W'(dump_idx - (SEL_W+1)'(1));
                dump_data = (dump_idx == (SEL_W+1)'(1)) ? '0 : reg_data;
            end
        end
    end

    // Cycle counter, halt capture and dump index bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_count <= '0;
            halted      <= 1'b0;
            halt_cause  <= 2'b00;
            bp_hit      <= '0;
            done        <= 1'b0;
            halt_pc     <= '0;
            dump_idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        cycle_count <= '0;
                        halted      <= 1'b0;
                        halt_cause  <= 2'b00;
                        bp_hit      <= '0;
                        done        <= 1'b0;
                        dump_idx    <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        halt_pc    <= pc;
                        halted     <= 1'b1;
                        halt_cause <= cause_nxt;
                        bp_hit     <= (cause_nxt == 2'b01) ? bp_first : '0;
                        dump_idx   <= '0;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                DUMP: begin
                    if (xfer) begin
                        if (last_beat) done     <= 1'b1;
                        else           dump_idx <= dump_idx + (SEL_W+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_run_monitor.sv
// Bench for pipe_run_monitor: a toy CPU (PC steps by 4 while cpu_run) and a
// patterned register file; expected dump beats go into a queue that a
// separate monitor drains on every accepted beat.
module tb_pipe_run_monitor;

    localparam int ADDR_W = 32, DATA_W = 32, NUM_BP = 4, CNT_W = 16, NUM_REGS = 32;
    localparam int SEL_W = 5;

    logic                     clk = 1'b0;
    logic                     rstn, start, pc_valid, cpu_run, dump_valid, dump_ready;
    logic                     dump_last, halted, done;
    logic [CNT_W-1:0]         timeout, cycle_count;
    logic [NUM_BP*ADDR_W-1:0] bp_addr;
    logic [NUM_BP-1:0]        bp_en, bp_hit;
    logic [ADDR_W-1:0]        pc;
    logic [SEL_W-1:0]         reg_sel;
    logic [DATA_W-1:0]        reg_data, dump_data;
    logic [SEL_W:0]           dump_idx;
    logic [1:0]               halt_cause;
    logic                     pc_clr, inv_en;
    logic [ADDR_W-1:0]        inv_pc;

    typedef struct {
        logic [SEL_W:0]    idx;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t q[$];
    int    vectors = 0, miscompares = 0, beats = 0;

    always #5 clk = ~clk;

    pipe_run_monitor #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_BP(NUM_BP),
                       .CNT_W(CNT_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .timeout(timeout),
        .bp_addr(bp_addr), .bp_en(bp_en), .pc(pc), .pc_valid(pc_valid),
        .cpu_run(cpu_run), .reg_sel(reg_sel), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_last(dump_last), .halted(halted),
        .halt_cause(halt_cause), .bp_hit(bp_hit), .cycle_count(cycle_count),
        .done(done)
    );

    function automatic logic [31:0] reg_val(input logic [4:0] i);
        return 32'hC0DE0000 + 32'(i) * 32'h101;
    endfunction

    // Toy CPU: PC advances only while enabled; register file is combinational.
    always @(posedge clk) begin
        if (pc_clr)       pc <= '0;
        else if (cpu_run) pc <= pc + 32'd4;
    end
    assign reg_data = reg_val(reg_sel);
    assign pc_valid = !(inv_en && (pc == inv_pc));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump(input logic [31:0] hpc);
        beat_t e;
        for (int k = 0; k <= NUM_REGS; k++) begin
            e.idx  = 6'(k);
            e.data = (k == 0) ? hpc : (k == 1) ? 32'd0 : reg_val(5'(k - 1));
            e.last = (k == NUM_REGS);
            q.push_back(e);
        end
    endtask

    // Monitor: every accepted beat is compared against the queue head.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (dump_valid && dump_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_unexpected: idx %0d with empty scoreboard", dump_idx);
                end else begin
                    e = q.pop_front();
                    chk("beat_idx",  dump_idx,  e.idx);
                    chk("beat_data", dump_data, e.data);
                    chk("beat_last", dump_last, e.last);
                    beats++;
                end
            end
        end
    end

    task automatic start_run(input logic [31:0] hpc);
        push_dump(hpc);
        beats  = 0;
        start  = 1'b1;
        pc_clr = 1'b1;
        tick();
        start  = 1'b0;
        pc_clr = 1'b0;
        chk("start_count", cycle_count, 0);
        chk("start_done",  done, 0);
        chk("start_run",   cpu_run, 1);
    endtask

    task automatic wait_halt(input logic [1:0] cause, input int cnt,
                             input logic [3:0] hit, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        chk("halt_reached", halted, 1);
        chk("halt_cause",   halt_cause, cause);
        chk("halt_count",   cycle_count, cnt);
        chk("halt_bp_hit",  bp_hit, hit);
        chk("halt_cpu_off", cpu_run, 0);
        chk("halt_valid",   dump_valid, 1);
    endtask

    task automatic wait_done(input bit stall);
        int n = 0;
        bit stalled = 0;
        while (!done && n < 100) begin
            if (stall && !stalled && dump_valid && dump_idx == 6'd5) begin
                dump_ready = 1'b0;
                stalled    = 1;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_data", dump_data, reg_val(5'd4));
                    chk("stall_sel",  reg_sel, 4);
                    chk("stall_idx",  dump_idx, 5);
                    tick();
                end
                dump_ready = 1'b1;
            end
            tick();
            n++;
        end
        chk("done_reached", done, 1);
        chk("done_valid",   dump_valid, 0);
        chk("done_beats",   beats, NUM_REGS + 1);
        chk("done_queue",   q.size(), 0);
        chk("done_halted",  halted, 1);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; dump_ready = 1'b1; timeout = 16'd1000;
        bp_addr = '0; bp_en = '0; pc_clr = 1'b1; inv_en = 1'b0; inv_pc = '0;
        tick();
        tick();
        rstn = 1'b1;
        pc_clr = 1'b0;
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_reg_sel", reg_sel, 0);
        chk("rst_valid",   dump_valid, 0);
        chk("rst_data",    dump_data, 0);
        chk("rst_idx",     dump_idx, 0);
        chk("rst_last",    dump_last, 0);
        chk("rst_halted",  halted, 0);
        chk("rst_cause",   halt_cause, 0);
        chk("rst_bp_hit",  bp_hit, 0);
        chk("rst_count",   cycle_count, 0);
        chk("rst_done",    done, 0);
        tick();

        // Breakpoint at 0x80 with a stall at beat 5.
        bp_addr[31:0] = 32'h80;
        bp_en = 4'b0001;
        start_run(32'h80);
        wait_halt(2'b01, 32, 4'b0001, 200);
        wait_done(1);

        // Re-arm from DONE: identical halt and dump.
        start_run(32'h80);
        wait_halt(2'b01, 32, 4'b0001, 200);
        wait_done(0);

        // Timeout only.
        bp_en = 4'b0000;
        start_run(32'hFA0);
        wait_halt(2'b10, 1000, 4'b0000, 1100);
        wait_done(0);

        // Invalid PC beats breakpoint and timeout on the same cycle.
        bp_en = 4'b0001; timeout = 16'd32; inv_en = 1'b1; inv_pc = 32'h80;
        start_run(32'h80);
        wait_halt(2'b11, 32, 4'b0000, 200);
        wait_done(0);

        // Breakpoint beats timeout; lowest enabled matching slot reported.
        inv_en = 1'b0;
        bp_addr[63:32] = 32'h80; bp_addr[95:64] = 32'h80;
        bp_en = 4'b0110;
        start_run(32'h80);
        wait_halt(2'b01, 32, 4'b0010, 200);
        wait_done(0);

        // Reset in the middle of the dump, then a clean run.
        bp_en = 4'b0001; timeout = 16'd1000;
        start_run(32'h80);
        wait_halt(2'b01, 32, 4'b0001, 200);
        begin
            int n = 0;
            while (dump_idx != 6'd10 && n < 50) begin
                tick();
                n++;
            end
        end
        chk("pre_rst_idx", dump_idx, 10);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        q.delete();
        chk("mrst_valid",  dump_valid, 0);
        chk("mrst_halted", halted, 0);
        chk("mrst_cause",  halt_cause, 0);
        chk("mrst_count",  cycle_count, 0);
        chk("mrst_idx",    dump_idx, 0);
        chk("mrst_run",    cpu_run, 0);
        tick();
        chk("mrst_idle_valid", dump_valid, 0);
        start_run(32'h80);
        wait_halt(2'b01, 32, 4'b0001, 200);
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_run_monitor.md
# pipe_run_monitor

Synthesizable run controller and state dumper for the pipelined MIPS CPU. It gates CPU execution and counts executed cycles. On a halt condition it freezes the CPU: a matching PC among `NUM_BP` breakpoints, a programmable cycle timeout, or an invalid PC. It then streams the halt PC and the whole register file through the CPU's `reg_sel`/`reg_data` debug port over a valid/ready interface. It sits between the CPU top and a trace sink (UART bridge or result-file writer).

## Interface
- `ADDR_W`, 32, PC width
- `DATA_W`, 32, register data width
- `NUM_BP`, 4, number of breakpoint comparators (1..8)
- `CNT_W`, 16, cycle counter / timeout width
- `NUM_REGS`, 32, registers dumped; `SEL_W = $clog2(NUM_REGS)`
- `clk` in 1: the only clock, rising edge
- `rstn` in 1: reset, synchronous, active-low
- `start` in 1: arm/run pulse
- `timeout` in CNT_W: cycle limit; 0 disables the limit
- `bp_addr` in NUM_BP*ADDR_W: breakpoint addresses; slot i is bits [i*ADDR_W +: ADDR_W]
- `bp_en` in NUM_BP: per-slot enable
- `pc` in ADDR_W: CPU PC
- `pc_valid` in 1: PC is legal; 0 means invalid/unknown
- `cpu_run` out 1: CPU clock enable
- `reg_sel` out SEL_W: register-file debug select
- `reg_data` in DATA_W: combinational read of `reg_sel`
- `dump_valid` out 1, `dump_ready` in 1: dump stream handshake
- `dump_data` out DATA_W, `dump_idx` out SEL_W+1, `dump_last` out 1: dump stream payload
- `halted` out 1, `halt_cause` out 2 (00 none, 01 breakpoint, 10 timeout, 11 invalid PC)
- `bp_hit` out NUM_BP: one-hot slot that fired
- `cycle_count` out CNT_W: executed cycles
- `done` out 1: dump complete

## Operation
- States: IDLE, RUN, DUMP, DONE.
- **IDLE**
  - `start` moves to RUN.
  - On that transition: clear `cycle_count`, `halted`, `halt_cause`, `bp_hit`, `done`.
- **RUN, halt conditions** (evaluated combinationally each cycle on the current `pc` and `cycle_count`):
  - inv = !pc_valid
  - bp[i] = bp_en[i] & (pc == bp_addr[i])
  - to = (timeout != 0) & (cycle_count == timeout)
  - hit = inv | (|bp) | to
- **RUN, run gating**
  - `cpu_run = (state == RUN) & !hit`. The CPU never advances past the halting PC.
  - `cycle_count` increments on every edge where `cpu_run` = 1. It saturates at all-ones.
- **RUN, on hit**
  - Capture `halt_pc = pc`, set `halted`, go to DUMP.
  - Cause priority: invalid PC > breakpoint > timeout. `halt_cause` shows only the winner.
  - `bp_hit` records the lowest-index matching slot, and only when the cause is 01; otherwise it is 0.
- **DUMP** streams `NUM_REGS+1` beats, with `dump_idx` k = 0..NUM_REGS:
  - k = 0: `dump_data = halt_pc` (zero-extended or truncated to DATA_W).
  - k ≥ 1: `reg_sel = k-1`; `dump_data = reg_data`, except register 0, which is forced to 0.
  - `dump_last` = 1 when k = NUM_REGS.
  - A beat transfers on `dump_valid & dump_ready`, then k increments.
  - After the last beat, go to DONE.
- **DONE**
  - `done` = 1; `halted` and the cause stay held.
  - `start` re-arms to RUN and clears state as in IDLE.
- `start` is ignored in RUN and DUMP.
- `start` is not level-sensitive: it is acted on only in IDLE/DONE.

## Timing
- Reset, sampled at the clk edge: state IDLE, `cpu_run` 0, `reg_sel` 0, `dump_valid` 0, `dump_data` 0, `dump_idx` 0, `dump_last` 0, `halted` 0, `halt_cause` 00, `bp_hit` 0, `cycle_count` 0, `done` 0, `halt_pc` 0.
- `start` seen at edge t: `cpu_run` = 1 during cycle t+1, unless a hit is already present.
- Hit in cycle t: `cpu_run` = 0 in the same cycle. State is DUMP and `dump_valid` = 1 from cycle t+1.
- A hit on the very first RUN cycle is legal: `cycle_count` = 0 at halt.
- Timeout N with no other hit: halts with `cycle_count` = N, i.e. exactly N executed CPU cycles.
- Backpressure: while `dump_valid & !dump_ready`, hold `dump_data`, `dump_idx`, `dump_last` and `reg_sel` stable.
- `dump_ready` held high: one beat per cycle, NUM_REGS+1 cycles total.
- `dump_valid` deasserts the cycle after the last transfer; `done` rises in that same cycle.
- `rstn` low mid-RUN or mid-DUMP: at the next edge, all outputs return to reset values and no further beats are issued.

## Test plan
- **Breakpoint halt.** bp_addr[0]=0x80, bp_en=0001, timeout=1000, CPU PC 0,4,8,… -> halt at PC 0x80, cycle_count=32, halt_cause=01, bp_hit=0001. Beat 0 = 0x00000080; beat 1 = 0; 33 beats total; last beat has dump_last=1.
- **Timeout.** bp_en=0, timeout=1000 -> halt_cause=10, cycle_count=1000, cpu_run low from that cycle.
- **Priority.** pc_valid=0 on the same cycle as a bp match and timeout -> halt_cause=11, bp_hit=0. A bp match coinciding with timeout -> cause 01.
- **Backpressure.** dump_ready low for 3 cycles while dump_idx=5 -> dump_data equals reg 4 and stays constant, and reg_sel stays 4, during the stall. The next accepted beat has idx 6.
- **Mid-dump reset.** rstn low for 1 cycle at dump_idx=10 -> next cycle dump_valid=0, halted=0, state IDLE. A subsequent start runs a clean new halt sequence.
- **Re-arm.** start in DONE -> cycle_count restarts at 0, done clears, second halt at the same breakpoint reproduces an identical dump.
